// File: rtl/tlc_pkg.sv
// Shared traffic-light types: light codes, vehicle-detector FSM states and
// default detector timing constants.
package tlc_pkg;
  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_YELLOW = 2'd1,
    LIGHT_GREEN  = 2'd2
  } light_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVE   = 2'd2,
    HOLD    = 2'd3
  } det_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_MIN_HOLD        = 8;
endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a level debouncer: a new level is
// accepted only after it persists for DEBOUNCE_CYCLES consecutive cycles.
module sensor_debounce
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic clear_n,
  input  logic sensor_raw,
  output logic det
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          sync1;
  logic          s;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      det   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= sensor_raw;
      s     <= sync1;
      // Any return to the accepted level restarts the qualification window.
      if (s == det) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        det <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vehicle_detector.sv
// Country-road vehicle detector: debounced loop input, saturating arrival
// counter, and the request FSM that drives the controller's x input.
module vehicle_detector
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_HOLD        = DEF_MIN_HOLD,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               sensor_raw,
  input  logic               country_green,
  input  logic               count_clr,
  output logic               x,
  output logic               car_arrived,
  output logic [COUNT_W-1:0] vehicle_count
);
  localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

  logic          det;
  logic          det_q;
  logic          rise;
  det_state_t    state;
  logic [HW-1:0] hold;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk        (clk),
    .clear_n    (clear_n),
    .sensor_raw (sensor_raw),
    .det        (det)
  );

  assign rise = det & ~det_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      det_q         <= 1'b0;
      car_arrived   <= 1'b0;
      vehicle_count <= '0;
    end else begin
      det_q       <= det;
      car_arrived <= rise;
      if (count_clr)
        vehicle_count <= '0;
      else if (rise && (vehicle_count != '1))
        vehicle_count <= vehicle_count + 1'b1;
    end
  end

  // x is registered alongside the state so it is high in every non-IDLE state.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      hold  <= '0;
      x     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (det) begin
            state <= REQUEST;
            x     <= 1'b1;
          end
        end
        REQUEST: begin
          if (country_green) state <= SERVE;
        end
        SERVE: begin
          if (!det) begin
            state <= HOLD;
            hold  <= HW'(MIN_HOLD - 1);
          end else if (!country_green) begin
            state <= REQUEST;
          end
        end
        HOLD: begin
          // A returning car resumes service before any gap or green-loss exit.
          if (det) begin
            state <= SERVE;
          end else if (!country_green || (hold == '0)) begin
            state <= IDLE;
            x     <= 1'b0;
          end else begin
            hold <= hold - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          x     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vehicle_detector.sv
// Scoreboarded bench for vehicle_detector: arrival pulses are predicted with
// their edge number and count, and scenario tasks check x timing inline.
module tb_vehicle_detector;
  logic       clk = 1'b0;
  logic       clear_n;
  logic       sensor_raw, country_green, count_clr;
  logic       x, car_arrived;
  logic [7:0] vehicle_count;
  logic       raw2, clr2;
  logic       x2, car2;
  logic [1:0] count2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_count = 0;

  typedef struct { int cyc; int cnt; } exp_t;
  exp_t sb[$];

  vehicle_detector dut (
    .clk (clk), .clear_n (clear_n), .sensor_raw (sensor_raw),
    .country_green (country_green), .count_clr (count_clr),
    .x (x), .car_arrived (car_arrived), .vehicle_count (vehicle_count)
  );

  vehicle_detector #(.COUNT_W(2)) u_sat (
    .clk (clk), .clear_n (clear_n), .sensor_raw (raw2),
    .country_green (1'b0), .count_clr (clr2),
    .x (x2), .car_arrived (car2), .vehicle_count (count2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish by time limit, required finish");
    $fatal(1, "watchdog");
  end

  // Arrival monitor: each pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (clear_n && car_arrived) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL arrival_unexpected: pulse at edge %0d, required none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc !== e.cyc || vehicle_count !== e.cnt[7:0]) begin
          bad++;
          $display("FAIL arrival: edge=%0d count=%0d, required edge=%0d count=%0d",
                   cyc, vehicle_count, e.cyc, e.cnt);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic expect_arrival(input int at_edge);
    exp_t e;
    exp_count = (exp_count < 255) ? exp_count + 1 : 255;
    e.cyc = at_edge;
    e.cnt = exp_count;
    sb.push_back(e);
  endtask

  task automatic check_x(input string name, input logic req);
    total++;
    if (x !== req) begin
      bad++;
      $display("FAIL %s: x=%b at edge %0d, required %b", name, x, cyc, req);
    end
  endtask

  task automatic test_reset();
    clear_n = 1'b0; sensor_raw = 1'b0; country_green = 1'b0; count_clr = 1'b0;
    raw2 = 1'b0; clr2 = 1'b0;
    tick(3);
    total++;
    if ({x, car_arrived, vehicle_count} !== 10'd0) begin
      bad++;
      $display("FAIL reset: x=%b arr=%b cnt=%0d, required 0 0 0", x, car_arrived, vehicle_count);
    end
    clear_n = 1'b1;
    tick(2);
  endtask

  task automatic test_glitch();
    sensor_raw = 1'b1;
    tick(3);
    sensor_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check_x("glitch_x", 1'b0);
    end
    total++;
    if (vehicle_count !== 8'd0) begin
      bad++;
      $display("FAIL glitch_count: count=%0d, required 0", vehicle_count);
    end
  endtask

  task automatic test_arrival();
    int k;
    k = cyc;
    sensor_raw = 1'b1;
    expect_arrival(k + 7);
    wait_until(k + 6);
    check_x("arrival_x_early", 1'b0);
    tick(1);
    check_x("arrival_x_rise", 1'b1);
    total++;
    if (vehicle_count !== 8'd1) begin
      bad++;
      $display("FAIL arrival_count: count=%0d, required 1", vehicle_count);
    end
  endtask

  task automatic test_leave_then_serve();
    int k;
    sensor_raw = 1'b0;
    tick(12);
    check_x("request_latched", 1'b1);
    k = cyc;
    country_green = 1'b1;
    wait_until(k + 9);
    check_x("leave_hold_end", 1'b1);
    tick(1);
    check_x("leave_x_fall", 1'b0);
  endtask

  task automatic test_serve_gap();
    int k, j;
    k = cyc;
    sensor_raw = 1'b1;
    expect_arrival(k + 7);
    wait_until(k + 10);
    check_x("serve_x", 1'b1);
    j = cyc;
    sensor_raw = 1'b0;
    wait_until(j + 14);
    check_x("gap_hold_end", 1'b1);
    tick(1);
    check_x("gap_x_fall", 1'b0);
  endtask

  task automatic test_hold_reappear();
    int k, j, drops;
    k = cyc;
    sensor_raw = 1'b1;
    expect_arrival(k + 7);
    wait_until(k + 10);
    j = cyc;
    sensor_raw = 1'b0;
    drops = 0;
    for (int i = 1; i <= 25; i++) begin
      tick(1);
      if (i == 5) begin
        sensor_raw = 1'b1;
        expect_arrival(j + 12);
      end
      if (x !== 1'b1) drops++;
    end
    total++;
    if (drops != 0) begin
      bad++;
      $display("FAIL reappear_x: x low on %0d edges, required 0", drops);
    end
    total++;
    if (vehicle_count !== 8'd4) begin
      bad++;
      $display("FAIL reappear_count: count=%0d, required 4", vehicle_count);
    end
  endtask

  task automatic test_reset_mid_serve();
    int k;
    #3 clear_n = 1'b0;
    #1;
    total++;
    if ({x, car_arrived, vehicle_count} !== 10'd0) begin
      bad++;
      $display("FAIL async_clear: x=%b arr=%b cnt=%0d, required 0 0 0", x, car_arrived, vehicle_count);
    end
    exp_count = 0;
    @(posedge clk); #1;
    k = cyc;
    clear_n = 1'b1;
    expect_arrival(k + 7);
    wait_until(k + 6);
    check_x("rerise_early", 1'b0);
    tick(1);
    check_x("rerise_x", 1'b1);
  endtask

  task automatic test_saturation();
    int k, n;
    for (n = 1; n <= 5; n++) begin
      raw2 = 1'b1;
      tick(8);
      raw2 = 1'b0;
      tick(8);
      total++;
      if (count2 !== 2'((n > 3) ? 3 : n)) begin
        bad++;
        $display("FAIL sat_count: after %0d arrivals count=%0d, required %0d", n, count2, (n > 3) ? 3 : n);
      end
    end
    k = cyc;
    raw2 = 1'b1;
    wait_until(k + 6);
    clr2 = 1'b1;
    tick(1);
    total++;
    if (car2 !== 1'b1 || count2 !== 2'd0) begin
      bad++;
      $display("FAIL clr_vs_arrival: arr=%b count=%0d, required 1 0", car2, count2);
    end
    clr2 = 1'b0;
    tick(2);
    total++;
    if (count2 !== 2'd0) begin
      bad++;
      $display("FAIL clr_hold: count=%0d, required 0", count2);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_arrival();
    test_leave_then_serve();
    test_serve_gap();
    test_hold_reappear();
    test_reset_mid_serve();
    test_saturation();
    tick(4);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d arrivals pending, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
